// File: rtl/if_pc_gen.sv
// if_pc_gen: fetch PC generator with branch-delay-slot redirect buffering.
// Ports: clk, rst_n (async low); stall_i, jump_req_i, jump_target_i, exc_req_i in;
//   pc_o, pc_valid_o, fetch_err_o (registered), jump_ack_o, flush_o (comb) out.
// Optional macro IF_PC_EXC_EN enables the exception redirect to EXC_VECTOR.
module if_pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_target_i,
  input  logic        exc_req_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        fetch_err_o,
  output logic        jump_ack_o,
  output logic        flush_o
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pend_q;
  logic [31:0] pend_d;
  logic        valid_q;
  logic        err_q;
  logic        load;
  logic        exc;

`ifdef IF_PC_EXC_EN
  assign exc = exc_req_i;
`else
  // Exception input and vector are inert in this build.
  logic unused_exc;
  assign unused_exc = exc_req_i ^ (^EXC_VECTOR);
  assign exc = 1'b0;
`endif

  // Mutually exclusive cycle classes; exc dominates everything.
  logic c_exc;
  logic c_pend_go;
  logic c_jmp_now;
  logic c_jmp_buf;
  logic c_seq;

  assign c_exc     = exc;
  assign c_pend_go = !exc && (state_q == PEND) && !stall_i;
  assign c_jmp_now = !exc && (state_q == RUN) && !stall_i && jump_req_i;
  assign c_jmp_buf = !exc && (state_q == RUN) && stall_i && jump_req_i;
  assign c_seq     = !exc && (state_q == RUN) && !stall_i && !jump_req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= 1'b1;
      if (load) begin
        pc_q  <= pc_d;
        err_q <= |pc_d[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pc_d    = pc_q;
    load    = 1'b0;
    unique case (1'b1)
`ifdef IF_PC_EXC_EN
      c_exc: begin
        pc_d    = EXC_VECTOR;
        load    = 1'b1;
        state_d = RUN;
        pend_d  = 32'h0;
      end
`endif
      c_pend_go: begin
        pc_d    = pend_q;
        load    = 1'b1;
        state_d = RUN;
      end
      c_jmp_now: begin
        pc_d = jump_target_i;
        load = 1'b1;
      end
      c_jmp_buf: begin
        pend_d  = jump_target_i;
        state_d = PEND;
      end
      c_seq: begin
        pc_d = pc_q + 32'd4;
        load = 1'b1;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  always_comb begin
    jump_ack_o = 1'b0;
    flush_o    = 1'b0;
    if (rst_n) begin
      jump_ack_o = c_jmp_now || c_jmp_buf;
`ifdef IF_PC_EXC_EN
      flush_o    = c_exc;
`endif
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid_q;
  assign fetch_err_o = err_q;

endmodule

// File: tb/tb_if_pc_gen.sv
// tb_if_pc_gen: scoreboard bench for if_pc_gen.
// Reference model predicts each cycle; registered results are queued and popped.
module tb_if_pc_gen;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'h8000_0180;
`ifdef IF_PC_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        jump_req_i;
  logic [31:0] jump_target_i;
  logic        exc_req_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        fetch_err_o;
  logic        jump_ack_o;
  logic        flush_o;

  if_pc_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .jump_req_i   (jump_req_i),
    .jump_target_i(jump_target_i),
    .exc_req_i    (exc_req_i),
    .pc_o         (pc_o),
    .pc_valid_o   (pc_valid_o),
    .fetch_err_o  (fetch_err_o),
    .jump_ack_o   (jump_ack_o),
    .flush_o      (flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_pt;
  logic        m_pend;
  logic        m_valid;
  logic        m_err;

  task automatic model_reset();
    m_pc    = RST_PC;
    m_pt    = 32'h0;
    m_pend  = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    sb.delete();
  endtask

  // One clock: drive, check comb outputs, predict, clock, pop and compare.
  task automatic cycle(input logic st, input logic jr,
                       input logic [31:0] tg, input logic ex);
    logic e_ack;
    logic e_flush;
    logic ex_on;
    logic ld;
    exp_t e;
    exp_t g;
    stall_i       = st;
    jump_req_i    = jr;
    jump_target_i = tg;
    exc_req_i     = ex;
    #1;
    ex_on   = EXC_ON && ex;
    e_ack   = !ex_on && !m_pend && jr;
    e_flush = ex_on;
    n_checks++;
    if (jump_ack_o !== e_ack) begin
      n_errors++;
      $display("FAIL ack: got %b want %b", jump_ack_o, e_ack);
    end
    n_checks++;
    if (flush_o !== e_flush) begin
      n_errors++;
      $display("FAIL flush: got %b want %b", flush_o, e_flush);
    end
    ld = 1'b0;
    if (ex_on) begin
      m_pc = EXC_PC; m_pend = 1'b0; m_pt = 32'h0; ld = 1'b1;
    end else if (m_pend) begin
      if (!st) begin
        m_pc = m_pt; m_pend = 1'b0; ld = 1'b1;
      end
    end else if (jr) begin
      if (st) begin
        m_pt = tg; m_pend = 1'b1;
      end else begin
        m_pc = tg; ld = 1'b1;
      end
    end else if (!st) begin
      m_pc = m_pc + 32'd4; ld = 1'b1;
    end
    if (ld) m_err = |m_pc[1:0];
    m_valid = 1'b1;
    e.pc = m_pc; e.valid = m_valid; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      g = sb.pop_front();
      if (pc_o !== g.pc || pc_valid_o !== g.valid || fetch_err_o !== g.err) begin
        n_errors++;
        $display("FAIL regs: got pc=%h v=%b e=%b want pc=%h v=%b e=%b",
                 pc_o, pc_valid_o, fetch_err_o, g.pc, g.valid, g.err);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall_i = 1'b0;
    jump_req_i = 1'b0;
    jump_target_i = 32'h0;
    exc_req_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    jump_req_i = 1'b1;
    exc_req_i = 1'b1;
    #1;
    n_checks++;
    if (pc_o !== RST_PC || pc_valid_o !== 1'b0 || fetch_err_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_regs: got %h/%b/%b want %h/0/0",
               pc_o, pc_valid_o, fetch_err_o, RST_PC);
    end
    n_checks++;
    if (jump_ack_o !== 1'b0 || flush_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_comb: got ack=%b flush=%b want 0/0", jump_ack_o, flush_o);
    end
    jump_req_i = 1'b0;
    exc_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (pc_o !== 32'hBFC0_0004 || pc_valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL first_edge: got %h v=%b want bfc00004 v=1", pc_o, pc_valid_o);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (pc_o !== 32'hBFC0_0008) begin
      n_errors++;
      $display("FAIL second_edge: got %h want bfc00008", pc_o);
    end
  endtask

  task automatic test_jump_unstalled();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (pc_o !== 32'hBFC0_0010) begin
      n_errors++;
      $display("FAIL pre_jump: got %h want bfc00010", pc_o);
    end
    cycle(1'b0, 1'b1, 32'h8000_1000, 1'b0);
    n_checks++;
    if (pc_o !== 32'h8000_1000) begin
      n_errors++;
      $display("FAIL jump_pc: got %h want 80001000", pc_o);
    end
  endtask

  task automatic test_stalled_redirect();
    cycle(1'b1, 1'b1, 32'h8000_2000, 1'b0);
    cycle(1'b1, 1'b1, 32'h8000_2000, 1'b0);
    cycle(1'b1, 1'b1, 32'h8000_2000, 1'b0);
    n_checks++;
    if (pc_o !== 32'h8000_1000) begin
      n_errors++;
      $display("FAIL stall_hold: got %h want 80001000", pc_o);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (pc_o !== 32'h8000_2000) begin
      n_errors++;
      $display("FAIL pend_pc: got %h want 80002000", pc_o);
    end
  endtask

  task automatic test_wrap_misalign();
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (pc_o !== 32'h0000_0000) begin
      n_errors++;
      $display("FAIL wrap: got %h want 00000000", pc_o);
    end
    cycle(1'b0, 1'b1, 32'h8000_0002, 1'b0);
    n_checks++;
    if (pc_o !== 32'h8000_0002 || fetch_err_o !== 1'b1) begin
      n_errors++;
      $display("FAIL misalign: got %h e=%b want 80000002 e=1", pc_o, fetch_err_o);
    end
    cycle(1'b0, 1'b1, 32'h0000_4000, 1'b0);
    n_checks++;
    if (fetch_err_o !== 1'b0) begin
      n_errors++;
      $display("FAIL err_clear: got %b want 0", fetch_err_o);
    end
  endtask

  task automatic test_pend_second();
    cycle(1'b1, 1'b1, 32'h0000_A000, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_B000, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_B000, 1'b0);
    n_checks++;
    if (pc_o !== 32'h0000_A000) begin
      n_errors++;
      $display("FAIL pend_first: got %h want 0000a000", pc_o);
    end
    cycle(1'b0, 1'b1, 32'h0000_B000, 1'b0);
    n_checks++;
    if (pc_o !== 32'h0000_B000) begin
      n_errors++;
      $display("FAIL pend_second: got %h want 0000b000", pc_o);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 32'h0001_0000, 1'b0);
    cycle(1'b0, 1'b1, 32'h0002_0000, 1'b0);
    cycle(1'b0, 1'b1, 32'h0003_0000, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (pc_o !== 32'h0003_0004) begin
      n_errors++;
      $display("FAIL b2b: got %h want 00030004", pc_o);
    end
  endtask

  task automatic test_exc();
    cycle(1'b1, 1'b1, 32'h0000_C000, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (EXC_ON && pc_o !== 32'h8000_0184) begin
      n_errors++;
      $display("FAIL exc_pc: got %h want 80000184", pc_o);
    end else if (!EXC_ON && pc_o !== 32'h0000_C000) begin
      n_errors++;
      $display("FAIL exc_ignored: got %h want 0000c000", pc_o);
    end
  endtask

  task automatic test_reset_mid_pend();
    cycle(1'b1, 1'b1, 32'h0000_D000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pc_o !== RST_PC || pc_valid_o !== 1'b0 || jump_ack_o !== 1'b0) begin
      n_errors++;
      $display("FAIL async_rst: got %h v=%b a=%b want %h v=0 a=0",
               pc_o, pc_valid_o, jump_ack_o, RST_PC);
    end
    model_reset();
    jump_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (pc_o !== 32'hBFC0_0008) begin
      n_errors++;
      $display("FAIL rst_pend_drop: got %h want bfc00008", pc_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int i = 0; i < 60; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), t,
            1'($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_jump_unstalled();
    test_stalled_redirect();
    test_wrap_misalign();
    test_pend_second();
    test_back_to_back();
    test_exc();
    test_reset_mid_pend();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
# if_pc_gen

Instruction-fetch program-counter generator for the five-stage MIPS core. It owns the fetch PC, advances it by 4 each unstalled cycle, and consumes jump/branch redirect requests issued by the ID-stage decoders. Redirects honour the MIPS branch delay slot, so the target is fetched only after the delay-slot instruction has been accepted. If the delay-slot fetch is stalled, the target is buffered until the fetch completes.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- EXC_VECTOR, 32'h8000_0180, exception entry PC (used only with IF_PC_EXC_EN).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- stall_i  in  1  hold fetch this cycle (I-cache miss or hazard).
- jump_req_i  in  1  ID requests a redirect; held until acknowledged.
- jump_target_i  in  32  redirect target, valid while jump_req_i=1.
- exc_req_i  in  1  exception redirect (only with IF_PC_EXC_EN).
- pc_o  out  32  current fetch PC (registered).
- pc_valid_o  out  1  pc_o is a valid fetch address (registered).
- fetch_err_o  out  1  pc_o[1:0]!=0, misaligned fetch (registered alongside pc_o).
- jump_ack_o  out  1  redirect captured this cycle (combinational).
- flush_o  out  1  exception redirect taken this cycle (combinational; only with IF_PC_EXC_EN).

## Operation
- States: RUN (no redirect pending) and PEND (target buffered in pend_target, delay slot not yet accepted).
- RUN, stall_i=0, jump_req_i=0: pc_o <= pc_o+4.
- RUN, stall_i=0, jump_req_i=1: delay slot accepted this cycle; pc_o <= jump_target_i; jump_ack_o=1; stay in RUN.
- RUN, stall_i=1, jump_req_i=1: pend_target <= jump_target_i; jump_ack_o=1; go to PEND; pc_o holds.
- RUN, stall_i=1, jump_req_i=0: everything holds.
- PEND, stall_i=1: hold; jump_ack_o=0.
- PEND, stall_i=0: pc_o <= pend_target; go to RUN; jump_ack_o=0.
- In PEND, jump_req_i is never acknowledged. ID must keep it asserted; it is serviced once the FSM is back in RUN.
- Arithmetic: pc_o+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Jump targets are used unmodified. Misalignment is only flagged on fetch_err_o, never corrected.
- fetch_err_o <= |next_pc[1:0], updated on every pc_o load.

## Timing
- Reset values (asynchronous): pc_o=RESET_PC, pc_valid_o=0, fetch_err_o=0, state=RUN, pend_target=0. jump_ack_o and flush_o are forced to 0 while rst_n=0.
- pc_valid_o rises on the first clk edge after rst_n deasserts and stays at 1.
- Redirect latency:
  - Unstalled: target appears on pc_o one cycle after jump_ack_o.
  - Stalled: target appears one cycle after the first cycle with stall_i=0.
- Handshake: jump_ack_o is asserted in the same cycle that jump_req_i is sampled and captured. ID drops or changes jump_req_i after that edge.
- Reset mid-PEND discards pend_target; fetch restarts at RESET_PC.

## Configuration
- Macro IF_PC_EXC_EN.
- Defined:
  - exc_req_i has highest priority and ignores stall_i: pc_o <= EXC_VECTOR, state <= RUN, pend_target discarded.
  - flush_o=1 and jump_ack_o=0 in that cycle.
- Undefined: exc_req_i is unconnected or ignored, flush_o is tied to 0, and no EXC_VECTOR logic is present.

## Test plan
- Reset release, no stall: pc_o goes BFC0_0000 -> BFC0_0004 -> BFC0_0008; pc_valid_o=1 from the first edge.
- RUN, stall_i=0, jump_req_i=1 with target 8000_1000 at pc_o=BFC0_0010: jump_ack_o=1 that cycle; next pc_o=8000_1000.
- Stalled redirect: stall_i=1 for 3 cycles with jump_req_i=1, target 8000_2000:
  - ack in cycle 1 only, then PEND.
  - pc_o holds for the stall.
  - pc_o=8000_2000 after stall_i falls.
- Wrap and misalignment:
  - pc_o=FFFF_FFFC with no stall gives next pc_o=0000_0000.
  - Target 8000_0002 gives pc_o=8000_0002 with fetch_err_o=1.
- Second request while in PEND: jump_ack_o stays 0 until the FSM returns to RUN, then that request is acknowledged.
- IF_PC_EXC_EN: exc_req_i=1 while in PEND with stall_i=1 gives flush_o=1 and next pc_o=8000_0180; the buffered target is never fetched.
